// File: rtl/div_pkg.sv
// Shared definitions for the divider sign controller: op encoding, default latency,
// pipeline metadata record and small arithmetic helpers.
package div_pkg;

  localparam int unsigned DefaultLatency = 8;

  // Matches funct3[1:0] of the RISC-V M-extension divide group.
  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef struct packed {
    logic        valid;
    div_op_e     op;
    logic        neg_q;
    logic        neg_r;
    logic        dbz;
    logic        ovf;
    logic [31:0] rs1;
  } div_meta_t;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // |0x80000000| wraps back to 0x80000000, which the unsigned divider handles correctly.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/div_meta_pipe.sv
// Stallable metadata shift register that runs in lockstep with the divider datapath.
module div_meta_pipe
  import div_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultLatency,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  div_meta_t        meta_i,
  input  logic [TAG_W-1:0] tag_i,
  output div_meta_t        meta_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  div_meta_t [DEPTH-1:0]             meta_q;
  logic      [DEPTH-1:0][TAG_W-1:0] tag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      tag_q  <= '0;
    end else if (!stall_i) begin
      meta_q[0] <= meta_i;
      tag_q[0]  <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        meta_q[i] <= meta_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_o = busy_o | meta_q[i].valid;
    end
  end

  assign meta_o = meta_q[DEPTH-1];
  assign tag_o  = tag_q[DEPTH-1];

endmodule

// File: rtl/div_sign_ctrl.sv
// Sign/exception wrapper around an unsigned multi-cycle divider.
// Define DIV_SIGN_OUT_REG_EN to register o_valid/o_result/o_tag (one extra cycle of latency).
module div_sign_ctrl
  import div_pkg::*;
#(
  parameter int unsigned LATENCY = DefaultLatency,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  output logic [31:0]      o_div_dividend,
  output logic [31:0]      o_div_divisor,
  input  logic [31:0]      i_div_quotient,
  input  logic [31:0]      i_div_remainder,
  output logic             o_valid,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  div_op_e          op;
  logic             is_signed;
  div_meta_t        meta_in;
  div_meta_t        tail;
  logic [TAG_W-1:0] tail_tag;
  logic             pipe_busy;
  logic [31:0]      result;

  assign op        = div_op_e'(i_op);
  assign is_signed = op_is_signed(op);

  assign o_div_dividend = is_signed ? abs32(i_rs1) : i_rs1;
  assign o_div_divisor  = is_signed ? abs32(i_rs2) : i_rs2;

  always_comb begin
    meta_in       = '0;
    meta_in.valid = i_valid;
    meta_in.op    = op;
    meta_in.neg_q = is_signed & (i_rs1[31] ^ i_rs2[31]) & (i_rs2 != 32'd0);
    meta_in.neg_r = is_signed & i_rs1[31];
    meta_in.dbz   = (i_rs2 == 32'd0);
    meta_in.ovf   = is_signed & (i_rs1 == 32'h8000_0000) & (i_rs2 == 32'hFFFF_FFFF);
    meta_in.rs1   = i_rs1;
  end

  div_meta_pipe #(
    .DEPTH(LATENCY),
    .TAG_W(TAG_W)
  ) u_meta_pipe (
    .clk_i  (clk),
    .rst_ni (rst),
    .stall_i(stall),
    .meta_i (meta_in),
    .tag_i  (i_tag),
    .meta_o (tail),
    .tag_o  (tail_tag),
    .busy_o (pipe_busy)
  );

  // Divide-by-zero outranks overflow; both override the raw divider output.
  always_comb begin
    result = '0;
    if (tail.dbz) begin
      result = op_is_rem(tail.op) ? tail.rs1 : 32'hFFFF_FFFF;
    end else if (tail.ovf) begin
      result = op_is_rem(tail.op) ? 32'd0 : 32'h8000_0000;
    end else if (op_is_rem(tail.op)) begin
      result = tail.neg_r ? neg32(i_div_remainder) : i_div_remainder;
    end else begin
      result = tail.neg_q ? neg32(i_div_quotient) : i_div_quotient;
    end
  end

`ifdef DIV_SIGN_OUT_REG_EN
  logic             valid_q;
  logic [31:0]      result_d, result_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  assign result_d = tail.valid ? result : '0;
  assign tag_d    = tail.valid ? tail_tag : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (!stall) begin
      valid_q  <= tail.valid;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_tag    = tag_q;
  assign o_busy   = pipe_busy | valid_q;
`else
  // Gate payload with valid so idle and reset outputs read as zero.
  assign o_valid  = tail.valid;
  assign o_result = tail.valid ? result : '0;
  assign o_tag    = tail.valid ? tail_tag : '0;
  assign o_busy   = pipe_busy;
`endif

endmodule

// File: doc/div_sign_ctrl.md
DIV_SIGN_CTRL -- requirements
Module: div_sign_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 8: clock edges from the divider's operand sample to its result.
REQ-002 SHALL have parameter TAG_W, default 5: width of the destination tag (rd).
REQ-003 SHALL have port clk  in  1  single clock; all flops rise-edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  in  1  freezes all state; same signal drives the divider's stall.
REQ-006 SHALL have port i_valid  in  1  operation request.
REQ-007 SHALL have port i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-008 SHALL have ports i_rs1, i_rs2  in  32  dividend, divisor.
REQ-009 SHALL have port i_tag  in  TAG_W  carried unchanged to o_tag.
REQ-010 SHALL have ports o_div_dividend, o_div_divisor  out  32  unsigned operands to the divider, combinational.
REQ-011 SHALL have ports i_div_quotient, i_div_remainder  in  32  divider results.
REQ-012 SHALL have ports o_valid 1, o_result 32, o_tag TAG_W  out  completed operation.
REQ-013 SHALL have port o_busy  out  1  high while any operation is in flight.

Function
REQ-014 SHALL drive o_div_* with |rs| for DIV/REM and raw rs for DIVU/REMU; |0x80000000| = 0x80000000.
REQ-015 SHALL, on i_valid & !stall, push {valid, op, neg_q, neg_r, dbz, ovf, rs1, tag} into a LATENCY-deep metadata shift register; i_valid & stall is ignored (caller holds the request).
REQ-016 SHALL set neg_q = signed op & (rs1[31]^rs2[31]) & rs2!=0, and neg_r = signed op & rs1[31].
REQ-017 SHALL set dbz = (rs2==0), and ovf = (op==DIV or REM) & rs1==0x80000000 & rs2==0xFFFFFFFF.
REQ-018 SHALL shift metadata only when !stall, so metadata stays aligned with the divider's data at every stage.
REQ-019 SHALL compute result at the tail: dbz -> quotient ops 0xFFFFFFFF, remainder ops rs1.
REQ-020 SHALL compute ovf -> DIV 0x80000000, REM 0; otherwise two's-complement negate quotient/remainder when neg_q/neg_r.
REQ-021 SHALL give dbz priority over ovf; all arithmetic is modulo 2^32.
REQ-022 SHALL assert o_valid for exactly one non-stalled cycle per accepted op; results in issue order; 1 op/cycle throughput.
REQ-023 SHALL hold o_valid/o_result/o_tag stable during stall.
REQ-024 SHALL drive o_busy = OR of all metadata valid bits (incl. output register when present).

Reset
REQ-025 SHALL clear all valid bits and o_valid, o_result, o_tag, o_busy to 0 immediately on rst low; payload flops may also clear.
REQ-026 SHALL discard in-flight ops on reset mid-operation; no result from them ever appears.
REQ-027 SHALL resume accepting on the first edge after rst deasserts.

Configuration
REQ-028 SHALL, with DIV_SIGN_OUT_REG_EN defined, register o_valid/o_result/o_tag: latency LATENCY+1 accepted edges.
REQ-029 SHALL, without DIV_SIGN_OUT_REG_EN, drive outputs combinationally from the metadata tail and divider results: latency LATENCY.

Structure
REQ-030 SHALL take the op encoding, the LATENCY default and the metadata record typedef from shared package div_pkg.
REQ-031 SHALL implement the shift register as sub-module div_meta_pipe (depth, stall, async clear); sign logic stays in the top.

Verification
REQ-032 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; o_valid 9 cycles after issue (macro on).
REQ-033 SHALL cover: DIVU 0xFFFFFFFF / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0xFFFFFFF9 / 0 -> 0xFFFFFFFF.
REQ-034 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-035 SHALL cover: 8 back-to-back ops, tags 0..7, stall 2 cycles at cycle 3 -> in-order results, tags 0..7, each 2 cycles later, no duplicates.
REQ-036 SHALL cover: rst low with 4 ops in flight -> o_valid 0, o_busy 0 at once; after release no stale o_valid.
REQ-037 SHALL cover: macro off, DIVU 100 / 7 -> 14 at 8 cycles; REMU -> 2.
